sensor_conditioner: RTL
=======================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter CLKS_PER_SEC, default 100, SHALL set the clk cycles per second_tick; legal range 2..65535.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable synchronized samples needed to change the debounced level; legal range 1..255.
REQ-004 Parameter MIN_VEHICLES, default 3, SHALL set the queue count that raises a request immediately; legal range 1..255.
REQ-005 Parameter MAX_WAIT_SEC, default 30, SHALL set the seconds a non-empty queue below MIN_VEHICLES waits before requesting.
REQ-006 Parameter HOLD_SEC, default 5, SHALL set the seconds SENSOR stays high after side_green rises.
REQ-007 Parameter STUCK_SEC, default 60, SHALL set the seconds of continuously high debounced level that declare a stuck detector.
REQ-008 Ports, one per line:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- loop_raw  in  1  raw side-road loop detector, asynchronous to clk, bouncy.
- side_green  in  1  high while the side-road light is green or yellow.
- SENSOR  out  1  side-road service request to the light controller.
- second_tick  out  1  one-cycle pulse once per second.
- vehicle_count  out  8  vehicles queued since the last service.
- fault  out  1  stuck-detector flag.

Function
REQ-009 loop_raw SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-010 The debounced level SHALL change only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any matching sample SHALL clear the stability counter.
REQ-011 A debounced 0->1 transition SHALL be one arrival; vehicle_count SHALL increment on the cycle after that transition and SHALL saturate at 255.
REQ-012 A free-running prescaler SHALL count 0..CLKS_PER_SEC-1 and wrap; second_tick SHALL be high only in the cycle the count equals CLKS_PER_SEC-1.
REQ-013 The FSM SHALL have four states: IDLE, WAIT, REQUEST and SERVE.
- IDLE: count==0; an arrival -> WAIT.
- WAIT: count>=MIN_VEHICLES, or MAX_WAIT_SEC ticks elapsed since entry -> REQUEST.
- REQUEST: SENSOR=1 until side_green==1 -> SERVE.
- SERVE: SENSOR=1 for HOLD_SEC ticks after entry, then 0; side_green falling -> IDLE if count==0, else WAIT.
REQ-014 Entering SERVE SHALL clear vehicle_count to 0.
- An arrival in the same cycle SHALL yield count 1, not 0.
- Arrivals during SERVE SHALL count normally.
REQ-015 A WAIT entry with count already >=MIN_VEHICLES SHALL move to REQUEST on the next cycle.
REQ-016 If side_green falls before HOLD_SEC expires, SENSOR SHALL drop in the same cycle the FSM leaves SERVE.
REQ-017 SENSOR SHALL be a registered output, high exactly in REQUEST and in SERVE-hold, with no combinational path from inputs.
REQ-018 The wait and hold second counters SHALL count only second_tick pulses and SHALL clear on every state entry.
- A tick coinciding with the entry cycle SHALL not count.
REQ-019 A debounced level held high for STUCK_SEC consecutive ticks SHALL set fault=1.
- While fault=1, SENSOR SHALL be forced to 1.
- fault SHALL clear on the first debounced 0.
- The held level SHALL count as one arrival only.
REQ-020 side_green==1 while in IDLE or WAIT SHALL not change state.

Reset
REQ-021 rst_n low SHALL asynchronously force: FSM=IDLE, SENSOR=0, second_tick=0, vehicle_count=0, fault=0, and the prescaler, synchronizer, debounce and second counters to 0.
REQ-022 Deassertion SHALL take effect on the next clk edge; the debounced level starts at 0.
- A high loop_raw at reset release SHALL register as an arrival after 2+DEBOUNCE_CYCLES cycles.
REQ-023 Reset mid-operation SHALL discard the queue and any pending request.

Verification (defaults, CLKS_PER_SEC=10 for speed)
REQ-024 A 2-cycle glitch on loop_raw -> no arrival; vehicle_count stays 0; SENSOR stays 0.
REQ-025 Three clean 20-cycle pulses on loop_raw -> count 1,2,3; SENSOR rises the cycle after the third increment; side_green=1 -> count=0; SENSOR falls exactly 5 ticks later.
REQ-026 One pulse, then quiet -> SENSOR rises after 30 second_ticks in WAIT.
REQ-027 loop_raw held high for 61 s -> fault=1 and SENSOR=1; loop_raw low -> fault=0 after 2+4 cycles.
REQ-028 rst_n asserted in REQUEST with count=5 -> SENSOR, count and fault 0 immediately, without waiting for a clock.
REQ-029 An arrival on the SERVE entry cycle -> vehicle_count=1; side_green falls -> FSM in WAIT.

Source files
------------

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: debounces a side-road loop detector, counts queued vehicles and raises a registered SENSOR service request.
// Ports: clk/rst_n clock and async active-low reset; loop_raw raw detector (async); side_green side-road green/yellow;
// SENSOR service request; second_tick 1-cycle pulse per second; vehicle_count queued vehicles; fault stuck-detector flag.
module sensor_conditioner #(
  parameter int CLKS_PER_SEC    = 100,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_VEHICLES    = 3,
  parameter int MAX_WAIT_SEC    = 30,
  parameter int HOLD_SEC        = 5,
  parameter int STUCK_SEC       = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       loop_raw,
  input  logic       side_green,
  output logic       SENSOR,
  output logic       second_tick,
  output logic [7:0] vehicle_count,
  output logic       fault
);
  typedef enum logic [1:0] {IDLE, WAIT, REQUEST, SERVE} state_t;
  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
  logic        diff, settle, arrival, tick, enter_serve;
  logic        sensor_q, sensor_d, fault_q, fault_d;
  logic [7:0]  stab_q, stab_d, count_q, count_d;
  logic [15:0] presc_q, presc_d, sec_q, sec_d, stuck_q, stuck_d;
  always_comb begin
    tick        = presc_q == 16'(CLKS_PER_SEC - 1);
    presc_d     = tick ? 16'd0 : presc_q + 16'd1;
    diff        = sync2_q != deb_q;
    settle      = diff && stab_q == 8'(DEBOUNCE_CYCLES - 1);
    deb_d       = settle ? sync2_q : deb_q;
    stab_d      = diff && !settle ? stab_q + 8'd1 : 8'd0;
    // arrival is the first cycle the debounced level reads high
    arrival     = deb_q && !deb_prev_q;
    enter_serve = state_q == REQUEST && side_green;
    count_d     = enter_serve ? {7'd0, arrival} : count_q + {7'd0, arrival && count_q != 8'hFF};
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = arrival ? WAIT : IDLE;
      WAIT:    state_d = count_q >= 8'(MIN_VEHICLES) || sec_q >= 16'(MAX_WAIT_SEC) ? REQUEST : WAIT;
      REQUEST: state_d = side_green ? SERVE : REQUEST;
      default: state_d = side_green ? SERVE : (count_d == 8'd0 ? IDLE : WAIT);
    endcase
    // the timer restarts on every transition, so a tick on the entry edge is dropped
    sec_d       = state_d != state_q ? 16'd0 : sec_q + {15'd0, tick && sec_q != 16'hFFFF};
    stuck_d     = !deb_q ? 16'd0 : stuck_q + {15'd0, tick && stuck_q < 16'(STUCK_SEC)};
    fault_d     = deb_d && (fault_q || stuck_q >= 16'(STUCK_SEC));
    sensor_d    = fault_d || state_d == REQUEST || (state_d == SERVE && sec_d < 16'(HOLD_SEC));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      stab_q     <= 8'd0;
      count_q    <= 8'd0;
      presc_q    <= 16'd0;
      sec_q      <= 16'd0;
      stuck_q    <= 16'd0;
      sensor_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= loop_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      stab_q     <= stab_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      stuck_q    <= stuck_d;
      sensor_q   <= sensor_d;
      fault_q    <= fault_d;
    end
  end
  assign SENSOR        = sensor_q;
  assign second_tick   = tick;
  assign vehicle_count = count_q;
  assign fault         = fault_q;
endmodule
